ssa_mult_seq: RTL and testbench
===============================

Name: ssa_mult_seq

Overview:
- Parametrised, multi-cycle successor to the combinational 8x8 split/convolve/merge multiplier.
- Splits both operands into DIGIT-bit digits and computes their exact acyclic convolution, one digit product per cycle. It then carry-merges the coefficients, one digit per cycle, into a 2*WIDTH-bit product.
- Adds a signed/unsigned mode and valid/ready handshakes on input and output.
- Sits in the SSA arithmetic path wherever a pipelined datapath feeds multiplies under backpressure.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of DIGIT and at least 4, otherwise the elaboration must fail.
DIGIT, 4, digit width in bits; L = WIDTH/DIGIT digits per operand.
ACC_W, 2*DIGIT+$clog2(L)+1, width of each convolution coefficient accumulator (derived; do not override).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
signed_mode  input  1  1: a, b and product are two's complement; 0: unsigned
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
p  output  2*WIDTH  product

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; in_ready=1, out_valid=0, p=0.
  - All counters, accumulators and carry are cleared.
  - Reset mid-operation abandons the operation with no output.
- FSM states: IDLE -> CONV -> MERGE -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - When in_valid & in_ready, latch a, b and signed_mode.
  - In signed mode, latch magnitudes |a| and |b| (-2^(WIDTH-1) maps to 2^(WIDTH-1) as unsigned), and latch neg = a[MSB]^b[MSB].
  - Clear the 2L-1 coefficient accumulators and go to CONV.
- CONV:
  - Lasts exactly L*L cycles; counters i (outer) and j (inner) each run 0..L-1.
  - Each cycle: coef[i+j] += digit_a[i]*digit_b[j], where each product is 2*DIGIT bits, zero-extended to ACC_W.
  - When i=j=L-1, go to MERGE.
- MERGE:
  - Lasts exactly 2L cycles; k runs 0..2L-1, carry starts at 0.
  - Each cycle: s = coef[k] + carry, with coef[2L-1] = 0. Result digit k = s[DIGIT-1:0]; carry = s >> DIGIT.
  - On the last cycle, register p = neg ? -result : result, taken modulo 2^(2*WIDTH). Go to DONE.
  - The final carry is zero by construction; a non-zero final carry is a design error and gets a simulation assertion.
- DONE:
  - out_valid=1; p is held stable while out_ready=0.
  - On out_valid & out_ready, go to IDLE. out_valid falls and in_ready rises on the next cycle; there is no same-cycle re-accept.
- in_ready=0 in CONV, MERGE and DONE; in_valid is ignored there. Inputs are sampled only on the accept edge.
- Latency: out_valid rises exactly L*L + 2L + 1 cycles after the accept edge (25 for default parameters).
- Throughput: one product per L*L + 2L + 2 cycles when out_ready is held high.
- p keeps its last value after the handshake, until the next MERGE completes or a reset occurs.
- Zero operands take the full fixed latency; there is no early-out.

Test Plan:
- Default params, unsigned, a=0xFFFF, b=0xFFFF, out_ready=1 -> p=0xFFFE0001; out_valid rises exactly 25 cycles after accept; in_ready high one cycle after the handshake.
- Signed, a=0xFFFD (-3), b=0x0005 -> p=0xFFFFFFF1 (-15). Signed a=0x8000, b=0x8000 -> p=0x40000000.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE while pulsing in_valid with other operands.
  - Response: p stable, in_ready=0, the new operands are not taken.
  - Then raise out_ready: handshake occurs in one cycle, next accept happens no earlier than the following cycle.
- Reset: drop rst_n during CONV cycle 7 -> immediately out_valid=0, p=0, in_ready=1. A following unsigned 0x1234*0x0010 then gives p=0x00012340.
- WIDTH=8, DIGIT=2, unsigned, 0xAB*0xCD -> p=0x88EF after 25 cycles. Signed 0x80*0x7F -> p=0xC080.
- Random regression: 10k back-to-back ops per parameter set (16/4, 8/2, 32/8) with random mode and random out_ready. Check every p against a behavioural multiply, and check the latency formula on every op.

Source files
------------

// File: rtl/ssa_mult_seq.sv
// Multi-cycle split/convolve/merge multiplier: one digit product per cycle into
// 2L-1 coefficient accumulators, then one carry-merge digit per cycle.
module ssa_mult_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4,
  localparam int L = WIDTH / DIGIT,
  localparam int ACC_W = 2*DIGIT + $clog2(L) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int NC = 2*L - 1;
  localparam int IW = (L > 1) ? $clog2(L) : 1;
  localparam int KW = $clog2(2*L);
  localparam logic [IW-1:0] LAST_IDX = IW'(L - 1);
  localparam logic [KW-1:0] LAST_K = KW'(2*L - 1);

  generate
    if ((DIGIT < 1) || (WIDTH < 4) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
      $error("ssa_mult_seq: WIDTH must be >= 4 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CONV, MERGE, DONE} state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     a_mag_reg, b_mag_reg;
  logic                 neg_reg;
  logic [IW-1:0]        i_reg, j_reg;
  logic [KW-1:0]        k_reg;
  logic [ACC_W-1:0]     carry_reg;
  logic [2*WIDTH-1:0]   result_reg, p_reg;

  logic                 accept;
  logic                 conv_last, merge_last;
  logic [DIGIT-1:0]     digit_a, digit_b;
  logic [2*DIGIT-1:0]   prod;
  logic [ACC_W-1:0]     prod_ext;
  logic [2*L*ACC_W-1:0] coef_vec;
  logic [ACC_W-1:0]     merge_coef;
  logic [ACC_W:0]       merge_sum;
  logic [ACC_W-1:0]     carry_next;
  logic [2*WIDTH-1:0]   result_next;

  assign accept     = in_valid && (state_reg == IDLE);
  assign conv_last  = (i_reg == LAST_IDX) && (j_reg == LAST_IDX);
  assign merge_last = (k_reg == LAST_K);

  assign digit_a  = a_mag_reg[int'(i_reg)*DIGIT +: DIGIT];
  assign digit_b  = b_mag_reg[int'(j_reg)*DIGIT +: DIGIT];
  assign prod     = {{DIGIT{1'b0}}, digit_a} * {{DIGIT{1'b0}}, digit_b};
  assign prod_ext = {{(ACC_W-2*DIGIT){1'b0}}, prod};

  // One accumulator per convolution coefficient; the top slot is the
  // always-zero coefficient consumed on the final merge step.
  genvar gi;
  generate
    for (gi = 0; gi < NC; gi++) begin : g_coef
      logic [ACC_W-1:0] acc_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_reg <= '0;
        end else if (accept) begin
          acc_reg <= '0;
        end else if ((state_reg == CONV) && ((int'(i_reg) + int'(j_reg)) == gi)) begin
          acc_reg <= acc_reg + prod_ext;
        end
      end
      assign coef_vec[gi*ACC_W +: ACC_W] = acc_reg;
    end
  endgenerate
  assign coef_vec[NC*ACC_W +: ACC_W] = '0;

  assign merge_coef = coef_vec[int'(k_reg)*ACC_W +: ACC_W];
  assign merge_sum  = {1'b0, merge_coef} + {1'b0, carry_reg};
  assign carry_next = ACC_W'(merge_sum >> DIGIT);

  always_comb begin
    result_next = result_reg;
    result_next[int'(k_reg)*DIGIT +: DIGIT] = merge_sum[DIGIT-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CONV;
      end
      CONV: begin
        if (conv_last) state_next = MERGE;
      end
      MERGE: begin
        if (merge_last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_mag_reg  <= '0;
      b_mag_reg  <= '0;
      neg_reg    <= 1'b0;
      i_reg      <= '0;
      j_reg      <= '0;
      k_reg      <= '0;
      carry_reg  <= '0;
      result_reg <= '0;
      p_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            // -2^(WIDTH-1) negates to itself, which reads correctly as unsigned.
            a_mag_reg  <= (signed_mode && a[WIDTH-1]) ? -a : a;
            b_mag_reg  <= (signed_mode && b[WIDTH-1]) ? -b : b;
            neg_reg    <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
            i_reg      <= '0;
            j_reg      <= '0;
            k_reg      <= '0;
            carry_reg  <= '0;
            result_reg <= '0;
          end
        end
        CONV: begin
          if (j_reg == LAST_IDX) begin
            j_reg <= '0;
            i_reg <= conv_last ? '0 : i_reg + 1'b1;
          end else begin
            j_reg <= j_reg + 1'b1;
          end
        end
        MERGE: begin
          k_reg      <= merge_last ? '0 : k_reg + 1'b1;
          carry_reg  <= carry_next;
          result_reg <= result_next;
          if (merge_last) begin
            p_reg <= neg_reg ? -result_next : result_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign p = p_reg;

  // Coefficients are exact, so the carry out of the top digit is always zero.
  assert property (@(posedge clk) disable iff (!rst_n)
                   ((state_reg == MERGE) && merge_last) |-> (carry_next == '0));

endmodule

// File: tb/tb_ssa_mult_seq.sv
// Drives 16/4, 8/2 and 32/8 instances in lockstep (all have L=4) and checks
// products against plain integer multiplication, plus handshake timing.
module tb_ssa_mult_seq;

  localparam int LAT    = 25;  // accept edge through first out_valid edge, inclusive
  localparam int PERIOD = 26;  // accept-to-accept with no backpressure

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        signed_mode = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;

  logic        ir8, ir16, ir32, ov8, ov16, ov32;
  logic [15:0] p8;
  logic [31:0] p16;
  logic [63:0] p32;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  int prev_acc = 0;
  int prev_hold = 0;
  int nop = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ssa_mult_seq #(.WIDTH(8), .DIGIT(2)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8),
    .a(a_in[7:0]), .b(b_in[7:0]), .signed_mode(signed_mode),
    .out_valid(ov8), .out_ready(out_ready), .p(p8)
  );
  ssa_mult_seq #(.WIDTH(16), .DIGIT(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16),
    .a(a_in[15:0]), .b(b_in[15:0]), .signed_mode(signed_mode),
    .out_valid(ov16), .out_ready(out_ready), .p(p16)
  );
  ssa_mult_seq #(.WIDTH(32), .DIGIT(8)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32),
    .a(a_in), .b(b_in), .signed_mode(signed_mode),
    .out_valid(ov32), .out_ready(out_ready), .p(p32)
  );

  // Product of the low w bits of x and y, signed or unsigned, mod 2^(2w).
  function automatic logic [63:0] ref_mul(logic [31:0] x, logic [31:0] y, bit s, int w);
    logic [63:0] m, m2, xe, ye;
    m  = (64'd1 << w) - 64'd1;
    m2 = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2*w)) - 64'd1);
    xe = {32'd0, x} & m;
    ye = {32'd0, y} & m;
    if (s && x[w-1]) xe = xe | ~m;
    if (s && y[w-1]) ye = ye | ~m;
    return (xe * ye) & m2;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with all DUTs idle; returns at a negedge after the
  // output handshake. hold = DONE cycles with out_ready low; pulse = offer
  // other operands while blocked.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input bit s,
                       input int hold, input bit pulse, input bit b2b);
    logic [63:0] e8, e16, e32;
    int c0, lat;
    e8  = ref_mul(x, y, s, 8);
    e16 = ref_mul(x, y, s, 16);
    e32 = ref_mul(x, y, s, 32);
    chk("in_ready_idle", {ir8, ir16, ir32}, 3'b111);
    a_in = x; b_in = y; signed_mode = s; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    c0 = cyc;
    in_valid = 1'b0; a_in = $urandom; b_in = $urandom; signed_mode = ~s;
    if (b2b) chk("throughput", c0 - prev_acc, PERIOD + prev_hold);
    prev_acc = c0;
    @(negedge clk);
    chk("in_ready_busy", {ir8, ir16, ir32}, 3'b000);
    repeat (100) begin
      if (ov16) break;
      @(negedge clk);
    end
    lat = cyc - c0 + 1;
    chk("out_valid_rise", {ov8, ov16, ov32}, 3'b111);
    chk("latency", lat, LAT);
    chk("p8", p8, e8);
    chk("p16", p16, e16);
    chk("p32", p32, e32);
    for (int h = 0; h < hold; h++) begin
      in_valid = pulse; a_in = $urandom; b_in = $urandom;
      @(negedge clk);
      chk("bp_p16", p16, e16);
      chk("bp_p8", p8, e8);
      chk("bp_valid_ready", {ov16, ir16, ov8, ir32}, 4'b1010);
    end
    out_ready = 1'b1;
    in_valid = pulse;
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_hs_valid", {ov8, ov16, ov32}, 3'b000);
    chk("post_hs_ready", {ir8, ir16, ir32}, 3'b111);
    chk("post_hs_p32", p32, e32);
    prev_hold = hold;
    $display("op %0d a=%h b=%h s=%0b hold=%0d lat=%0d p8=%h p16=%h p32=%h",
             nop, x, y, s, hold, lat, p8, p16, p32);
    nop++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] x, y;
    int hold;

    repeat (3) @(negedge clk);
    chk("reset_valid", {ov8, ov16, ov32}, 3'b000);
    chk("reset_ready", {ir8, ir16, ir32}, 3'b111);
    chk("reset_p16", p16, 32'h0);
    chk("reset_p32", p32, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(32'h0000FFFF, 32'h0000FFFF, 1'b0, 0, 1'b0, 1'b0);
    chk("ffff_sq", p16, 32'hFFFE0001);
    do_op(32'h0000FFFD, 32'h00000005, 1'b1, 0, 1'b0, 1'b1);
    chk("m3_x5", p16, 32'hFFFFFFF1);
    do_op(32'h00008000, 32'h00008000, 1'b1, 0, 1'b0, 1'b1);
    chk("min_sq", p16, 32'h40000000);
    do_op(32'h000000AB, 32'h000000CD, 1'b0, 10, 1'b1, 1'b1);
    chk("w8_ab_cd", p8, 16'h88EF);
    do_op(32'h00000080, 32'h0000007F, 1'b1, 0, 1'b0, 1'b1);
    chk("w8_min_max", p8, 16'hC080);

    // Abandon an operation in CONV cycle 7.
    a_in = 32'hAAAAAAAA; b_in = 32'h55555555; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {ov8, ov16, ov32}, 3'b000);
    chk("mid_rst_ready", {ir8, ir16, ir32}, 3'b111);
    chk("mid_rst_p16", p16, 32'h0);
    chk("mid_rst_p8", p8, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("abandoned_no_output", {ov8, ov16, ov32}, 3'b000);
    do_op(32'h00001234, 32'h00000010, 1'b0, 0, 1'b0, 1'b0);
    chk("after_rst", p16, 32'h00012340);

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 7))
        0: x = 32'h0;
        1: x = 32'hFFFFFFFF;
        2: x = 32'h80000000;
        default: x = $urandom;
      endcase
      y = ($urandom_range(0, 7) == 0) ? 32'h80008080 : $urandom;
      hold = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      do_op(x, y, 1'($urandom_range(0, 1)), hold, 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
